aes_block_sequencer: RTL and testbench

- Stage that sits directly in front of and behind the AES-128 encryption core.
- Accepts key and plaintext as a stream of 32-bit words and assembles them into 128-bit key and plaintext vectors for the core.
- Holds those vectors stable for the core's fixed pipeline latency, then captures the 128-bit ciphertext.
- Presents the ciphertext on a valid/ready result interface.

---
 rtl/aes_block_sequencer.sv | 132 +++++++++++++
 tb/tb_aes_block_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_sequencer.sv
// Front/back-end sequencer for an AES-128 core: packs 32-bit key and plaintext words
// into 128-bit vectors, holds them for CORE_LAT edges, then returns the ciphertext.
module aes_block_sequencer #(
  parameter int CORE_LAT = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_is_key,
  output logic [127:0] core_in,
  output logic [127:0] core_key,
  input  logic [127:0] core_out,
  output logic         busy,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         err_nokey
);

  localparam logic [7:0] LAT_INIT = CORE_LAT[7:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [95:0] key_sh;
  logic [95:0] data_sh;
  logic [1:0]  key_cnt;
  logic [1:0]  data_cnt;
  logic        key_ok;
  logic [7:0]  lat_cnt;

  logic        acc;
  logic        acc_key;
  logic        acc_pt;
  logic        acc_drop;
  logic        launch;
  logic        capture;
  logic        res_hs;

  // Word acceptance decode; s_ready is only ever high in IDLE.
  always_comb begin
    acc      = s_valid && s_ready;
    acc_key  = acc && s_is_key;
    acc_pt   = acc && !s_is_key && key_ok;
    acc_drop = acc && !s_is_key && !key_ok;
    launch   = acc_pt && (data_cnt == 2'd3);
    capture  = (state == RUN) && (lat_cnt == 8'd1);
    res_hs   = (state == DONE) && res_valid && res_ready;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch)  state_nxt = RUN;
      RUN:     if (capture) state_nxt = DONE;
      DONE:    if (res_hs)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      err_nokey <= 1'b0;
      res_valid <= 1'b0;
      key_cnt   <= 2'd0;
      data_cnt  <= 2'd0;
      key_ok    <= 1'b0;
      lat_cnt   <= 8'd0;
    end else begin
      state     <= state_nxt;
      s_ready   <= (state_nxt == IDLE);
      busy      <= (state_nxt != IDLE);
      err_nokey <= acc_drop;

      if (acc_key) begin
        key_cnt  <= key_cnt + 2'd1;
        data_cnt <= 2'd0;
        if (key_cnt == 2'd0) key_ok <= 1'b0;
        if (key_cnt == 2'd3) key_ok <= 1'b1;
      end else if (acc_pt) begin
        data_cnt <= data_cnt + 2'd1;
      end

      if (launch) begin
        lat_cnt <= LAT_INIT;
      end else if (state == RUN) begin
        lat_cnt <= lat_cnt - 8'd1;
      end

      if (capture) begin
        res_valid <= 1'b1;
      end else if (res_hs) begin
        res_valid <= 1'b0;
      end
    end
  end

  // Word assembly and the vectors held for the core; the shift registers keep the
  // three most recent words of each group so the fourth word completes the vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sh   <= '0;
      data_sh  <= '0;
      core_key <= '0;
      core_in  <= '0;
      res_data <= '0;
    end else begin
      if (acc_key) begin
        key_sh <= {key_sh[63:0], s_data};
        if (key_cnt == 2'd3) core_key <= {key_sh, s_data};
      end
      if (acc_pt) begin
        data_sh <= {data_sh[63:0], s_data};
        if (data_cnt == 2'd3) core_in <= {data_sh, s_data};
      end
      if (capture) res_data <= core_out;
    end
  end

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Directed bench for aes_block_sequencer: one instance against a latency-11 core
// stand-in, a second at CORE_LAT=1 against an inverting stub core.
module tb_aes_block_sequencer;

  localparam int LAT_A = 11;
  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] P3  = 128'hffeeddccbbaa99887766554433221100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic [31:0]  s_data;
  logic         s_is_key;
  logic         res_ready;

  logic         s_ready_a, busy_a, res_valid_a, err_nokey_a;
  logic [127:0] core_in_a, core_key_a, core_out_a, res_data_a;
  logic         s_ready_b, busy_b, res_valid_b, err_nokey_b;
  logic [127:0] core_in_b, core_key_b, core_out_b, res_data_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_block_sequencer #(.CORE_LAT(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a),
    .s_data(s_data), .s_is_key(s_is_key), .core_in(core_in_a),
    .core_key(core_key_a), .core_out(core_out_a), .busy(busy_a),
    .res_valid(res_valid_a), .res_ready(res_ready), .res_data(res_data_a),
    .err_nokey(err_nokey_a)
  );

  aes_block_sequencer #(.CORE_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_data(s_data), .s_is_key(s_is_key), .core_in(core_in_b),
    .core_key(core_key_b), .core_out(core_out_b), .busy(busy_b),
    .res_valid(res_valid_b), .res_ready(res_ready), .res_data(res_data_b),
    .err_nokey(err_nokey_b)
  );

  // Core stand-in: knows the FIPS-197 C.1 answer, otherwise a keyed mix; the result
  // only appears at the core output after LAT_A-1 edges, so early capture reads stale data.
  function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] p);
    if (k == C1K && p == C1P) return C1C;
    return p ^ {k[63:0], k[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
  endfunction

  logic [127:0] pipe_a [0:LAT_A-2];
  always @(posedge clk) begin
    pipe_a[0] <= core_model(core_key_a, core_in_a);
    for (int i = 1; i < LAT_A - 1; i++) pipe_a[i] <= pipe_a[i-1];
  end
  assign core_out_a = pipe_a[LAT_A-2];
  assign core_out_b = ~core_in_b;

  task automatic check_vec(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic send_word(input logic is_key, input logic [31:0] d);
    @(negedge clk);
    s_valid  = 1'b1;
    s_is_key = is_key;
    s_data   = d;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_block(input logic is_key, input logic [127:0] v);
    logic [127:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      send_word(is_key, t[127:96]);
      t = t << 32;
    end
  endtask

  task automatic wait_valid(input int max_cyc, output int cyc);
    cyc = 0;
    while (!res_valid_a && cyc < max_cyc) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [127:0] t;
    rst_n     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_is_key  = 1'b0;
    res_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_s_ready", s_ready_a, 0);
    check_vec("rst_busy", busy_a, 0);
    check_vec("rst_res_valid", res_valid_a, 0);
    check_vec("rst_err_nokey", err_nokey_a, 0);
    check_vec("rst_core_in", core_in_a, 0);
    check_vec("rst_core_key", core_key_a, 0);
    check_vec("rst_res_data", res_data_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_vec("s_ready_after_rst", s_ready_a, 1);

    // Plaintext with no key: each word dropped and flagged.
    t = C1P;
    for (int i = 0; i < 4; i++) begin
      send_word(1'b0, t[127:96]);
      t = t << 32;
      check_vec("nokey_err", err_nokey_a, 1);
      check_vec("nokey_busy", busy_a, 0);
    end
    @(posedge clk);
    #1;
    check_vec("nokey_err_clear", err_nokey_a, 0);
    check_vec("nokey_no_result", res_valid_a, 0);

    // FIPS-197 C.1 block.
    send_block(1'b1, C1K);
    check_vec("c1_core_key", core_key_a, C1K);
    check_vec("c1_busy_before_pt", busy_a, 0);
    send_block(1'b0, C1P);
    check_vec("c1_core_in", core_in_a, C1P);
    check_vec("c1_busy", busy_a, 1);
    check_vec("c1_s_ready", s_ready_a, 0);
    wait_valid(50, cyc);
    check_vec("c1_latency", cyc, LAT_A);
    check_vec("c1_res_data", res_data_a, C1C);

    // Backpressure, with key words offered while not ready.
    @(negedge clk);
    s_valid  = 1'b1;
    s_is_key = 1'b1;
    s_data   = 32'hdeadbeef;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check_vec("bp_hold", {res_valid_a, s_ready_a, busy_a, res_data_a}, {1'b1, 1'b0, 1'b1, C1C});
    end
    @(negedge clk);
    s_valid   = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check_vec("bp_release", {res_valid_a, busy_a, s_ready_a}, 3'b001);

    // Key reuse: next block needs plaintext only.
    send_block(1'b0, P2);
    check_vec("reuse_busy", busy_a, 1);
    check_vec("reuse_key_kept", core_key_a, C1K);
    wait_valid(50, cyc);
    check_vec("reuse_latency", cyc, LAT_A);
    check_vec("reuse_res_data", res_data_a, core_model(C1K, P2));
    @(posedge clk);
    #1;
    check_vec("reuse_handshake", {res_valid_a, s_ready_a}, 2'b01);

    // Abort: partial plaintext, then a new key load starts.
    send_word(1'b0, P2[127:96]);
    check_vec("abort_pt0_ok", err_nokey_a, 0);
    send_word(1'b0, P2[95:64]);
    send_word(1'b1, K2[127:96]);
    check_vec("abort_busy", busy_a, 0);
    send_word(1'b0, 32'h11111111);
    check_vec("abort_partial_key_err", err_nokey_a, 1);
    send_word(1'b1, K2[95:64]);
    send_word(1'b1, K2[63:32]);
    send_word(1'b1, K2[31:0]);
    check_vec("abort_core_key", core_key_a, K2);
    send_word(1'b0, P3[127:96]);
    send_word(1'b0, P3[95:64]);
    send_word(1'b0, P3[63:32]);
    check_vec("abort_no_early_launch", busy_a, 0);
    send_word(1'b0, P3[31:0]);
    check_vec("abort_launch", busy_a, 1);
    check_vec("abort_core_in", core_in_a, P3);
    wait_valid(50, cyc);
    check_vec("abort_res_data", res_data_a, core_model(K2, P3));
    @(posedge clk);
    #1;

    // Reset in the middle of RUN.
    send_block(1'b0, P2);
    check_vec("midrun_busy", busy_a, 1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("midrun_rst", {s_ready_a, busy_a, res_valid_a}, 3'b000);
    check_vec("midrun_core_in", core_in_a, 0);
    check_vec("midrun_core_key", core_key_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(1'b0, P2[127:96]);
    check_vec("midrun_key_lost", err_nokey_a, 1);

    // CORE_LAT=1 against the inverting stub.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_block(1'b1, C1K);
    send_block(1'b0, 128'h0);
    check_vec("lat1_busy", busy_b, 1);
    check_vec("lat1_not_yet", res_valid_b, 0);
    @(posedge clk);
    #1;
    check_vec("lat1_valid", res_valid_b, 1);
    check_vec("lat1_res_data", res_data_b, {128{1'b1}});
    check_vec("lat1_long_core_pending", res_valid_a, 0);
    @(posedge clk);
    #1;
    check_vec("lat1_handshake", {res_valid_b, s_ready_b}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
